// File: rtl/noc_pkg.sv
// Shared definitions for the NoC network interface: flit type codes, field
// offsets and the encodings of the transmit and receive state machines.
package noc_pkg;

    localparam int FLIT_W_DEF = 8;
    localparam int NODE_W_DEF = 2;
    localparam int TYPE_W     = 2;

    localparam logic [1:0] FT_IDLE = 2'b00;
    localparam logic [1:0] FT_HEAD = 2'b01;
    localparam logic [1:0] FT_BODY = 2'b10;
    localparam logic [1:0] FT_TAIL = 2'b11;

    localparam logic [1:0] T_IDLE = 2'd0;
    localparam logic [1:0] T_HEAD = 2'd1;
    localparam logic [1:0] T_BODY = 2'd2;
    localparam logic [1:0] T_TAIL = 2'd3;

    localparam logic [1:0] R_HEAD = 2'd0;
    localparam logic [1:0] R_BODY = 2'd1;
    localparam logic [1:0] R_TAIL = 2'd2;

    // Head flit: type | dest | src | zero padding
    function automatic int head_dest_lsb(input int flit_w, input int node_w);
        return flit_w - TYPE_W - node_w;
    endfunction

    function automatic int head_src_lsb(input int flit_w, input int node_w);
        return flit_w - TYPE_W - 2 * node_w;
    endfunction

endpackage

// File: rtl/noc_ni_rx_assembler.sv
// Receive side of the network interface: rebuilds head/body/tail packets from
// the router's local output and holds one completed message for the PE.
//   state  | meaning
//   R_HEAD | waiting for a head flit
//   R_BODY | head seen, waiting for the body flit
//   R_TAIL | body seen, waiting for the tail flit
module noc_ni_rx_assembler
    import noc_pkg::*;
#(
    parameter int   FLIT_W = FLIT_W_DEF,
    parameter int   NODE_W = NODE_W_DEF,
    localparam int  PL_W   = 2 * (FLIT_W - TYPE_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] flit_in,
    input  logic              flit_in_en,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic [PL_W-1:0]   rx_data,
    output logic [NODE_W-1:0] rx_src,
    output logic              rx_err,
    output logic              rx_overflow
);

    localparam int HALF_W  = FLIT_W - TYPE_W;
    localparam int SRC_LSB = head_src_lsb(FLIT_W, NODE_W);

    logic [1:0]        rx_state;
    logic [NODE_W-1:0] src_q;
    logic [HALF_W-1:0] upper_q;
    logic [1:0]        ftype;
    logic [HALF_W-1:0] payload;
    logic              complete;

    assign ftype    = flit_in[FLIT_W-1 -: TYPE_W];
    assign payload  = flit_in[HALF_W-1:0];
    assign complete = flit_in_en && (rx_state == R_TAIL) && (ftype == FT_TAIL);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state    <= R_HEAD;
            src_q       <= '0;
            upper_q     <= '0;
            rx_valid    <= 1'b0;
            rx_data     <= '0;
            rx_src      <= '0;
            rx_err      <= 1'b0;
            rx_overflow <= 1'b0;
        end else begin
            rx_err <= 1'b0;
            if (flit_in_en && ftype != FT_IDLE) begin
                case (rx_state)
                    R_BODY: begin
                        case (ftype)
                            FT_HEAD: begin
                                rx_err <= 1'b1;
                                src_q  <= flit_in[SRC_LSB +: NODE_W];
                            end
                            FT_BODY: begin
                                upper_q  <= payload;
                                rx_state <= R_TAIL;
                            end
                            FT_TAIL: begin
                                rx_err   <= 1'b1;
                                rx_state <= R_HEAD;
                            end
                            default: ;
                        endcase
                    end
                    R_TAIL: begin
                        case (ftype)
                            FT_HEAD: begin
                                rx_err   <= 1'b1;
                                src_q    <= flit_in[SRC_LSB +: NODE_W];
                                rx_state <= R_BODY;
                            end
                            FT_BODY: begin
                                rx_err   <= 1'b1;
                                rx_state <= R_HEAD;
                            end
                            FT_TAIL: rx_state <= R_HEAD;
                            default: ;
                        endcase
                    end
                    default: begin
                        if (ftype == FT_HEAD) begin
                            src_q    <= flit_in[SRC_LSB +: NODE_W];
                            rx_state <= R_BODY;
                        end else begin
                            rx_err <= 1'b1;
                        end
                    end
                endcase
            end

            // A completed packet may only replace a message that is being consumed.
            if (complete) begin
                if (!rx_valid || rx_ready) begin
                    rx_valid <= 1'b1;
                    rx_data  <= {upper_q, payload};
                    rx_src   <= src_q;
                end else begin
                    rx_overflow <= 1'b1;
                end
            end else if (rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/noc_network_interface.sv
// PE-side endpoint of a router's local port: splits PE messages into 3-flit
// packets for injection and hands reassembled packets back to the PE.
//   state  | meaning
//   T_IDLE | ready to accept a PE message
//   T_HEAD | offering the head flit
//   T_BODY | offering the body flit (upper payload half)
//   T_TAIL | offering the tail flit (lower payload half)
module noc_network_interface
    import noc_pkg::*;
#(
    parameter int   FLIT_W = FLIT_W_DEF,
    parameter int   NODE_W = NODE_W_DEF,
    localparam int  PL_W   = 2 * (FLIT_W - TYPE_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NODE_W-1:0] current_node,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [NODE_W-1:0] tx_dest,
    input  logic [PL_W-1:0]   tx_data,
    output logic [FLIT_W-1:0] flit_out,
    output logic              flit_valid,
    input  logic              noc_ready,
    input  logic [FLIT_W-1:0] flit_in,
    input  logic              flit_in_en,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic [PL_W-1:0]   rx_data,
    output logic [NODE_W-1:0] rx_src,
    output logic              rx_err,
    output logic              rx_overflow
);

    localparam int HALF_W   = FLIT_W - TYPE_W;
    localparam int DEST_LSB = head_dest_lsb(FLIT_W, NODE_W);
    localparam int SRC_LSB  = head_src_lsb(FLIT_W, NODE_W);

    logic [1:0]        tx_state;
    logic [NODE_W-1:0] dest_q;
    logic [NODE_W-1:0] src_q;
    logic [PL_W-1:0]   data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= T_IDLE;
            dest_q   <= '0;
            src_q    <= '0;
            data_q   <= '0;
        end else begin
            case (tx_state)
                T_IDLE: begin
                    if (tx_valid) begin
                        dest_q   <= tx_dest;
                        src_q    <= current_node;
                        data_q   <= tx_data;
                        tx_state <= T_HEAD;
                    end
                end
                T_HEAD:  if (noc_ready) tx_state <= T_BODY;
                T_BODY:  if (noc_ready) tx_state <= T_TAIL;
                default: if (noc_ready) tx_state <= T_IDLE;
            endcase
        end
    end

    assign tx_ready   = (tx_state == T_IDLE);
    assign flit_valid = (tx_state != T_IDLE);

    // Flits come purely from registered fields, so they hold while stalled.
    always_comb begin
        flit_out = '0;
        case (tx_state)
            T_HEAD: begin
                flit_out[FLIT_W-1 -: TYPE_W]  = FT_HEAD;
                flit_out[DEST_LSB +: NODE_W]  = dest_q;
                flit_out[SRC_LSB +: NODE_W]   = src_q;
            end
            T_BODY:  flit_out = {FT_BODY, data_q[PL_W-1 -: HALF_W]};
            T_TAIL:  flit_out = {FT_TAIL, data_q[HALF_W-1:0]};
            default: ;
        endcase
    end

    noc_ni_rx_assembler #(
        .FLIT_W (FLIT_W),
        .NODE_W (NODE_W)
    ) u_rx (
        .clk         (clk),
        .rst         (rst),
        .flit_in     (flit_in),
        .flit_in_en  (flit_in_en),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .rx_src      (rx_src),
        .rx_err      (rx_err),
        .rx_overflow (rx_overflow)
    );

endmodule
